// File: rtl/dmem_arbiter.sv
// ----------------------------------------------------------------------------
// dmem_arbiter
//
// Round-robin arbiter that lets CORE_COUNT cores share one single-port
// synchronous data memory. Each access takes one ACCESS cycle, in which the
// winner's request is presented to the memory. A read adds one READ cycle,
// in which the memory's registered read data is returned to that core.
//
// Ports:
//   clk        system clock; all state changes on the rising edge
//   rstN       synchronous active-low reset
//   req        per-core access request (bit i = core i)
//   wrEn       per-core write flag (1 = write, 0 = read), qualified by req
//   addr       per-core address, core i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   wrData     per-core write data, sliced like addr
//   gnt        one-hot grant, high for the ACCESS cycle only
//   rdValid    one-hot read-data-valid, high for the READ cycle only
//   rdData     read data broadcast to all cores, zero outside READ
//   memAddr    shared memory address
//   memWrEn    shared memory write enable
//   memWrData  shared memory write data
//   memRdData  memory read data, valid one cycle after a read address
//   busy       high whenever the arbiter is not IDLE
// ----------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int CORE_COUNT = 4,
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 12
) (
  input  logic                             clk,
  input  logic                             rstN,
  input  logic [CORE_COUNT-1:0]            req,
  input  logic [CORE_COUNT-1:0]            wrEn,
  input  logic [CORE_COUNT*ADDR_WIDTH-1:0] addr,
  input  logic [CORE_COUNT*DATA_WIDTH-1:0] wrData,
  output logic [CORE_COUNT-1:0]            gnt,
  output logic [CORE_COUNT-1:0]            rdValid,
  output logic [DATA_WIDTH-1:0]            rdData,
  output logic [ADDR_WIDTH-1:0]            memAddr,
  output logic                             memWrEn,
  output logic [DATA_WIDTH-1:0]            memWrData,
  input  logic [DATA_WIDTH-1:0]            memRdData,
  output logic                             busy
);

  localparam int IDX_W = (CORE_COUNT > 1) ? $clog2(CORE_COUNT) : 1;
  localparam logic [IDX_W:0] N_L = (IDX_W+1)'(CORE_COUNT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    READ   = 2'd2
  } state_t;

  state_t                  state_q;
  logic [IDX_W-1:0]        ptr_q;
  logic [IDX_W-1:0]        winner_q;
  logic [CORE_COUNT-1:0]   gnt_q;
  logic [CORE_COUNT-1:0]   rd_valid_q;
  logic [ADDR_WIDTH-1:0]   mem_addr_q;
  logic                    mem_wr_en_q;
  logic [DATA_WIDTH-1:0]   mem_wr_data_q;
  logic                    busy_q;

  logic [IDX_W-1:0]        winner_d;
  logic [IDX_W-1:0]        cand_d;
  logic                    found_d;
  logic [CORE_COUNT-1:0]   win_onehot_d;
  logic [ADDR_WIDTH-1:0]   win_addr_d;
  logic [DATA_WIDTH-1:0]   win_data_d;
  logic                    win_wr_d;

  // (base + offs) mod CORE_COUNT; both operands are already below CORE_COUNT,
  // so a single conditional subtract is enough.
  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base,
                                                input logic [IDX_W-1:0] offs);
    logic [IDX_W:0] sum;
    sum = {1'b0, base} + {1'b0, offs};
    if (sum >= N_L) begin
      sum = sum - N_L;
    end
    return sum[IDX_W-1:0];
  endfunction

  // Round-robin pick: first requesting core at or above the pointer, wrapping.
  always_comb begin
    winner_d = ptr_q;
    cand_d   = ptr_q;
    found_d  = 1'b0;
    for (int k = 0; k < CORE_COUNT; k++) begin
      cand_d = wrap_add(ptr_q, IDX_W'(k));
      if (!found_d && req[cand_d]) begin
        found_d  = 1'b1;
        winner_d = cand_d;
      end
    end
  end

  always_comb begin
    win_onehot_d = CORE_COUNT'(1) << winner_d;
    win_addr_d   = addr[winner_d*ADDR_WIDTH +: ADDR_WIDTH];
    win_data_d   = wrData[winner_d*DATA_WIDTH +: DATA_WIDTH];
    win_wr_d     = wrEn[winner_d];
  end

  // Single FSM process. The memory-side registers double as the latched
  // request: they are loaded when leaving IDLE and cleared when leaving
  // ACCESS, so the mem* outputs never see req combinationally.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      winner_q      <= '0;
      gnt_q         <= '0;
      rd_valid_q    <= '0;
      mem_addr_q    <= '0;
      mem_wr_en_q   <= 1'b0;
      mem_wr_data_q <= '0;
      busy_q        <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|req) begin
            state_q       <= ACCESS;
            winner_q      <= winner_d;
            gnt_q         <= win_onehot_d;
            mem_addr_q    <= win_addr_d;
            mem_wr_en_q   <= win_wr_d;
            mem_wr_data_q <= win_data_d;
            busy_q        <= 1'b1;
          end
        end
        ACCESS: begin
          gnt_q         <= '0;
          mem_addr_q    <= '0;
          mem_wr_en_q   <= 1'b0;
          mem_wr_data_q <= '0;
          ptr_q         <= wrap_add(winner_q, IDX_W'(1));
          if (mem_wr_en_q) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            // The grant vector already is the winner's one-hot code.
            state_q    <= READ;
            rd_valid_q <= gnt_q;
          end
        end
        READ: begin
          rd_valid_q <= '0;
          state_q    <= IDLE;
          busy_q     <= 1'b0;
        end
        default: begin
          state_q       <= IDLE;
          gnt_q         <= '0;
          rd_valid_q    <= '0;
          mem_addr_q    <= '0;
          mem_wr_en_q   <= 1'b0;
          mem_wr_data_q <= '0;
          busy_q        <= 1'b0;
        end
      endcase
    end
  end

  // A read interrupted by reset must not signal valid data, even when reset
  // arrives during the READ cycle itself, so the read return path is masked
  // by rstN.
  assign rdValid   = rd_valid_q & {CORE_COUNT{rstN}};
  assign rdData    = ((state_q == READ) && rstN) ? memRdData : '0;
  assign gnt       = gnt_q;
  assign memAddr   = mem_addr_q;
  assign memWrEn   = mem_wr_en_q;
  assign memWrData = mem_wr_data_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  localparam int N  = 4;
  localparam int AW = 12;
  localparam int DW = 12;

  logic            clk = 1'b0;
  logic            rstN;
  logic [N-1:0]    req;
  logic [N-1:0]    wrEn;
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] wrData;
  logic [N-1:0]    gnt;
  logic [N-1:0]    rdValid;
  logic [DW-1:0]   rdData;
  logic [AW-1:0]   memAddr;
  logic            memWrEn;
  logic [DW-1:0]   memWrData;
  logic [DW-1:0]   memRdData;
  logic            busy;

  always #5 clk = ~clk;

  dmem_arbiter #(.CORE_COUNT(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rstN(rstN), .req(req), .wrEn(wrEn), .addr(addr), .wrData(wrData),
    .gnt(gnt), .rdValid(rdValid), .rdData(rdData), .memAddr(memAddr),
    .memWrEn(memWrEn), .memWrData(memWrData), .memRdData(memRdData), .busy(busy)
  );

  // Single-port synchronous memory with a preload port used only by the bench.
  logic [DW-1:0] mem_model [0:(1<<AW)-1];
  logic          ld_en;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_data;

  always @(posedge clk) begin
    if (ld_en) mem_model[ld_addr] <= ld_data;
    else if (memWrEn) mem_model[memAddr] <= memWrData;
    memRdData <= mem_model[memAddr];
  end

  int checks = 0;
  int errors = 0;
  logic mon_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_quiet(input string pfx);
    check({pfx, ".gnt"}, 64'(gnt), 64'd0);
    check({pfx, ".rdValid"}, 64'(rdValid), 64'd0);
    check({pfx, ".rdData"}, 64'(rdData), 64'd0);
    check({pfx, ".memAddr"}, 64'(memAddr), 64'd0);
    check({pfx, ".memWrEn"}, 64'(memWrEn), 64'd0);
    check({pfx, ".memWrData"}, 64'(memWrData), 64'd0);
    check({pfx, ".busy"}, 64'(busy), 64'd0);
  endtask

  // Structural invariants checked every cycle away from the active edge.
  always @(negedge clk) begin
    if (mon_en) begin
      check("inv.gnt_onehot0", 64'($onehot0(gnt)), 64'd1);
      check("inv.rdValid_onehot0", 64'($onehot0(rdValid)), 64'd1);
      check("inv.gnt_rdValid_excl", 64'((|gnt) && (|rdValid)), 64'd0);
    end
  end

  typedef struct {
    string     name;
    logic      rst_n;
    logic [3:0]  req;
    logic [3:0]  wr;
    logic [47:0] addr;
    logic [47:0] wdata;
    logic [3:0]  gnt;
    logic [3:0]  rdv;
    logic [11:0] rdd;
    logic [11:0] maddr;
    logic        mwe;
    logic [11:0] mwd;
    logic        busy;
    logic        chk_mem;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string name, input logic rst_n, input logic [3:0] rq,
                     input logic [3:0] wr, input logic [47:0] a, input logic [47:0] wd,
                     input logic [3:0] g, input logic [3:0] rv, input logic [11:0] rd,
                     input logic [11:0] ma, input logic mwe, input logic [11:0] mwd,
                     input logic bz, input logic cm);
    vec_t v;
    v.name = name; v.rst_n = rst_n; v.req = rq; v.wr = wr; v.addr = a; v.wdata = wd;
    v.gnt = g; v.rdv = rv; v.rdd = rd; v.maddr = ma; v.mwe = mwe; v.mwd = mwd;
    v.busy = bz; v.chk_mem = cm;
    vecs.push_back(v);
  endtask

  localparam logic [47:0] Z   = 48'h0;
  localparam logic [47:0] AWR = {12'h0FF, 12'h05A, 12'h0EE, 12'h0DD};
  localparam logic [47:0] WDW = {12'h777, 12'h123, 12'h666, 12'h555};
  localparam logic [47:0] ARD = {12'h0AA, 12'h0BB, 12'h010, 12'h0CC};
  localparam logic [47:0] ARR = {12'h023, 12'h022, 12'h021, 12'h020};
  localparam logic [47:0] ARB = {12'h023, 12'h022, 12'h021, 12'h05A};

  logic [3:0] exp_g [4] = '{4'b0001, 4'b1000, 4'b0001, 4'b0001};
  logic [3:0] got_g [4];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_gnt;
    int dbl;
    logic [3:0] prev_gnt;
    logic       c3_done;

    rstN = 1'b0; req = '0; wrEn = '0; addr = '0; wrData = '0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0;

    // Preload memory while the arbiter is held in reset.
    ld_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      case (i)
        0: begin ld_addr = 12'h010; ld_data = 12'hABC; end
        1: begin ld_addr = 12'h020; ld_data = 12'h111; end
        2: begin ld_addr = 12'h021; ld_data = 12'h222; end
        3: begin ld_addr = 12'h022; ld_data = 12'h333; end
        default: begin ld_addr = 12'h023; ld_data = 12'h444; end
      endcase
      @(posedge clk); #1;
    end
    ld_en = 1'b0;
    mon_en = 1'b1;

    //   name        rst req     wr      addr wdata gnt     rdv     rdData  mAddr   mWe mWd     busy chkmem
    add("rst1",      0, 4'b1011, 4'b0110, ARR, WDW, 4'b0000, 4'b0000, 12'h000, 12'h000, 0, 12'h000, 0, 1);
    add("rst2",      0, 4'b0110, 4'b1001, AWR, WDW, 4'b0000, 4'b0000, 12'h000, 12'h000, 0, 12'h000, 0, 1);
    add("idle1",     1, 4'b0000, 4'b0000, Z,   Z,   4'b0000, 4'b0000, 12'h000, 12'h000, 0, 12'h000, 0, 1);
    add("idle2",     1, 4'b0000, 4'b1111, AWR, WDW, 4'b0000, 4'b0000, 12'h000, 12'h000, 0, 12'h000, 0, 1);
    add("wr_acc",    1, 4'b0100, 4'b1111, AWR, WDW, 4'b0100, 4'b0000, 12'h000, 12'h05A, 1, 12'h123, 1, 1);
    add("wr_hold",   1, 4'b0100, 4'b1111, AWR, WDW, 4'b0000, 4'b0000, 12'h000, 12'h000, 0, 12'h000, 0, 1);
    add("wr_idle",   1, 4'b0000, 4'b0000, Z,   Z,   4'b0000, 4'b0000, 12'h000, 12'h000, 0, 12'h000, 0, 1);
    add("rd_acc",    1, 4'b0010, 4'b1101, ARD, Z,   4'b0010, 4'b0000, 12'h000, 12'h010, 0, 12'h000, 1, 1);
    add("rd_read",   1, 4'b0010, 4'b1101, ARD, Z,   4'b0000, 4'b0010, 12'hABC, 12'h000, 0, 12'h000, 1, 0);
    add("rd_idle",   1, 4'b0010, 4'b1101, ARD, Z,   4'b0000, 4'b0000, 12'h000, 12'h000, 0, 12'h000, 0, 1);
    add("rst_mid",   0, 4'b0000, 4'b0000, Z,   Z,   4'b0000, 4'b0000, 12'h000, 12'h000, 0, 12'h000, 0, 1);
    add("rr0_acc",   1, 4'b1111, 4'b0000, ARR, Z,   4'b0001, 4'b0000, 12'h000, 12'h020, 0, 12'h000, 1, 1);
    add("rr0_read",  1, 4'b1111, 4'b0000, ARR, Z,   4'b0000, 4'b0001, 12'h111, 12'h000, 0, 12'h000, 1, 0);
    add("rr0_idle",  1, 4'b1111, 4'b0000, ARR, Z,   4'b0000, 4'b0000, 12'h000, 12'h000, 0, 12'h000, 0, 1);
    add("rr1_acc",   1, 4'b1110, 4'b0000, ARR, Z,   4'b0010, 4'b0000, 12'h000, 12'h021, 0, 12'h000, 1, 1);
    add("rr1_read",  1, 4'b1110, 4'b0000, ARR, Z,   4'b0000, 4'b0010, 12'h222, 12'h000, 0, 12'h000, 1, 0);
    add("rr1_idle",  1, 4'b1110, 4'b0000, ARR, Z,   4'b0000, 4'b0000, 12'h000, 12'h000, 0, 12'h000, 0, 1);
    add("rr2_acc",   1, 4'b1100, 4'b0000, ARR, Z,   4'b0100, 4'b0000, 12'h000, 12'h022, 0, 12'h000, 1, 1);
    add("rr2_read",  1, 4'b1100, 4'b0000, ARR, Z,   4'b0000, 4'b0100, 12'h333, 12'h000, 0, 12'h000, 1, 0);
    add("rr2_idle",  1, 4'b1100, 4'b0000, ARR, Z,   4'b0000, 4'b0000, 12'h000, 12'h000, 0, 12'h000, 0, 1);
    add("rr3_acc",   1, 4'b1000, 4'b0000, ARR, Z,   4'b1000, 4'b0000, 12'h000, 12'h023, 0, 12'h000, 1, 1);
    add("rr3_read",  1, 4'b1000, 4'b0000, ARR, Z,   4'b0000, 4'b1000, 12'h444, 12'h000, 0, 12'h000, 1, 0);
    add("rr3_idle",  1, 4'b1000, 4'b0000, ARR, Z,   4'b0000, 4'b0000, 12'h000, 12'h000, 0, 12'h000, 0, 1);
    add("wrap0_acc", 1, 4'b1001, 4'b0000, ARR, Z,   4'b0001, 4'b0000, 12'h000, 12'h020, 0, 12'h000, 1, 1);
    add("wrap0_read",1, 4'b1001, 4'b0000, ARR, Z,   4'b0000, 4'b0001, 12'h111, 12'h000, 0, 12'h000, 1, 0);
    add("wrap0_idle",1, 4'b1001, 4'b0000, ARR, Z,   4'b0000, 4'b0000, 12'h000, 12'h000, 0, 12'h000, 0, 1);
    add("wrap3_acc", 1, 4'b1000, 4'b0000, ARR, Z,   4'b1000, 4'b0000, 12'h000, 12'h023, 0, 12'h000, 1, 1);
    add("wrap3_read",1, 4'b1000, 4'b0000, ARR, Z,   4'b0000, 4'b1000, 12'h444, 12'h000, 0, 12'h000, 1, 0);
    add("wrap3_idle",1, 4'b1000, 4'b0000, ARR, Z,   4'b0000, 4'b0000, 12'h000, 12'h000, 0, 12'h000, 0, 1);
    add("rb_acc",    1, 4'b0001, 4'b0000, ARB, Z,   4'b0001, 4'b0000, 12'h000, 12'h05A, 0, 12'h000, 1, 1);
    add("rb_read",   1, 4'b0001, 4'b0000, ARB, Z,   4'b0000, 4'b0001, 12'h123, 12'h000, 0, 12'h000, 1, 0);
    add("rb_idle",   1, 4'b0001, 4'b0000, ARB, Z,   4'b0000, 4'b0000, 12'h000, 12'h000, 0, 12'h000, 0, 1);
    add("idle_end",  1, 4'b0000, 4'b0000, Z,   Z,   4'b0000, 4'b0000, 12'h000, 12'h000, 0, 12'h000, 0, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      rstN = vecs[i].rst_n; req = vecs[i].req; wrEn = vecs[i].wr;
      addr = vecs[i].addr;  wrData = vecs[i].wdata;
      @(posedge clk); #1;
      $display("vec %0d %s: req=%b gnt=%b rdValid=%b rdData=%03h memAddr=%03h memWrEn=%b busy=%b",
               i, vecs[i].name, req, gnt, rdValid, rdData, memAddr, memWrEn, busy);
      check({vecs[i].name, ".gnt"}, 64'(gnt), 64'(vecs[i].gnt));
      check({vecs[i].name, ".rdValid"}, 64'(rdValid), 64'(vecs[i].rdv));
      check({vecs[i].name, ".rdData"}, 64'(rdData), 64'(vecs[i].rdd));
      check({vecs[i].name, ".busy"}, 64'(busy), 64'(vecs[i].busy));
      if (vecs[i].chk_mem) begin
        check({vecs[i].name, ".memAddr"}, 64'(memAddr), 64'(vecs[i].maddr));
        check({vecs[i].name, ".memWrEn"}, 64'(memWrEn), 64'(vecs[i].mwe));
        check({vecs[i].name, ".memWrData"}, 64'(memWrData), 64'(vecs[i].mwd));
      end
    end

    // Starvation: core 0 requests writes continuously, core 3 once.
    rstN = 1'b0; req = '0;
    @(posedge clk); #1;
    rstN = 1'b1;
    req = 4'b1001; wrEn = 4'b1001;
    addr = {12'h103, 12'h000, 12'h000, 12'h100};
    wrData = {12'h0A3, 12'h000, 12'h000, 12'h0A0};
    n_gnt = 0; dbl = 0; prev_gnt = '0; c3_done = 1'b0;
    for (int cyc = 0; cyc < 24 && n_gnt < 4; cyc++) begin
      @(posedge clk); #1;
      if (gnt != '0) begin
        if (prev_gnt != '0) dbl++;
        got_g[n_gnt] = gnt;
        n_gnt++;
        $display("starve grant %0d: gnt=%b memAddr=%03h memWrData=%03h", n_gnt, gnt, memAddr, memWrData);
        if (gnt == 4'b1000) begin
          c3_done = 1'b1;
          req[3] = 1'b0;
        end
      end
      prev_gnt = gnt;
    end
    check("starve.grant_count", 64'(n_gnt), 64'd4);
    check("starve.core3_served", 64'(c3_done), 64'd1);
    check("starve.back_to_back_gnt", 64'(dbl), 64'd0);
    for (int k = 0; k < 4; k++) begin
      if (k < n_gnt) check($sformatf("starve.order%0d", k), 64'(got_g[k]), 64'(exp_g[k]));
    end
    check("starve.mem103", 64'(mem_model[12'h103]), 64'h0A3);
    req = '0; wrEn = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_quiet("starve_end");

    // Write in the ACCESS cycle that coincides with reset is still committed.
    req = 4'b0001; wrEn = 4'b0001; addr = {36'h0, 12'h200}; wrData = {36'h0, 12'h0A5};
    @(posedge clk); #1;
    $display("rstwr access: gnt=%b memAddr=%03h memWrEn=%b", gnt, memAddr, memWrEn);
    check("rstwr.gnt", 64'(gnt), 64'b0001);
    rstN = 1'b0;
    @(posedge clk); #1;
    check("rstwr.mem200", 64'(mem_model[12'h200]), 64'h0A5);
    check_quiet("rstwr_after");
    rstN = 1'b1; req = '0; wrEn = '0;

    // Reset during a READ cycle: no rdValid, pointer back to 0.
    req = 4'b0010; wrEn = '0; addr = {12'h000, 12'h022, 12'h010, 12'h000}; wrData = '0;
    @(posedge clk); #1;
    $display("rstrd access: gnt=%b memAddr=%03h", gnt, memAddr);
    check("rstrd.gnt", 64'(gnt), 64'b0010);
    @(posedge clk); #1;
    rstN = 1'b0;
    #1;
    $display("rstrd read-cycle reset: rdValid=%b rdData=%03h", rdValid, rdData);
    check("rstrd.rdValid", 64'(rdValid), 64'd0);
    check("rstrd.rdData", 64'(rdData), 64'd0);
    @(posedge clk); #1;
    check_quiet("rstrd_after");
    rstN = 1'b1; req = 4'b0110;
    @(posedge clk); #1;
    $display("rstrd rearb: req=%b gnt=%b memAddr=%03h", req, gnt, memAddr);
    check("rstrd.rearb_gnt", 64'(gnt), 64'b0010);
    check("rstrd.rearb_addr", 64'(memAddr), 64'h010);
    @(posedge clk); #1;
    check("rstrd.rd1_valid", 64'(rdValid), 64'b0010);
    check("rstrd.rd1_data", 64'(rdData), 64'hABC);
    @(posedge clk); #1;
    req = 4'b0100;
    @(posedge clk); #1;
    $display("rstrd second: gnt=%b memAddr=%03h", gnt, memAddr);
    check("rstrd.gnt2", 64'(gnt), 64'b0100);
    check("rstrd.addr2", 64'(memAddr), 64'h022);
    @(posedge clk); #1;
    check("rstrd.rd2_valid", 64'(rdValid), 64'b0100);
    check("rstrd.rd2_data", 64'(rdData), 64'h333);
    @(posedge clk); #1;
    req = '0;
    @(posedge clk); #1;
    check_quiet("final_idle");

    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Round-robin arbiter that shares one single-port synchronous data memory between CORE_COUNT processor cores in the multicore build.
- Sits between each core's data-memory port (address, write enable, write data) and the shared memory.
- Serialises accesses, returns read data to the granted core only, and guarantees no core is starved.

Parameters:
- CORE_COUNT, 4, number of requesting cores (2..8).
- ADDR_WIDTH, 12, data memory address width.
- DATA_WIDTH, 12, data memory word width.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rstN  input  1  synchronous, active-low reset.
- req  input  CORE_COUNT  per-core access request; bit i = core i.
- wrEn  input  CORE_COUNT  per-core write flag (1 = write, 0 = read), qualified by req.
- addr  input  CORE_COUNT*ADDR_WIDTH  per-core address; core i at slice [i*ADDR_WIDTH +: ADDR_WIDTH].
- wrData  input  CORE_COUNT*DATA_WIDTH  per-core write data, sliced the same way as addr.
- gnt  output  CORE_COUNT  one-hot grant; high for exactly the ACCESS cycle.
- rdValid  output  CORE_COUNT  one-hot read-data-valid; high for exactly the READ cycle.
- rdData  output  DATA_WIDTH  read data, broadcast to all cores; meaningful only with rdValid.
- memAddr  output  ADDR_WIDTH  shared memory address.
- memWrEn  output  1  shared memory write enable.
- memWrData  output  DATA_WIDTH  shared memory write data.
- memRdData  input  DATA_WIDTH  memory read data; valid one cycle after memAddr is presented with memWrEn=0.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (rstN=0 at a rising edge):
  - state=IDLE, priority pointer=0, latched winner/addr/data/wr cleared.
  - All outputs 0: gnt, rdValid, rdData, memAddr, memWrEn, memWrData, busy.
- FSM states: IDLE, ACCESS, READ.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise pick the winner: the first set req bit scanning upward from the pointer, wrapping mod CORE_COUNT.
  - At the edge, latch the winner index and its addr, wrData and wrEn; go to ACCESS.
  - In IDLE, memAddr, memWrEn and memWrData are all 0.
- ACCESS (one cycle):
  - gnt[winner]=1; memAddr, memWrData and memWrEn are driven from the latched values.
  - Pointer becomes (winner+1) mod CORE_COUNT at the edge.
  - Next state: latched write -> IDLE; latched read -> READ.
- READ (one cycle):
  - rdValid[winner]=1, rdData=memRdData; next state IDLE.
  - Outside READ, rdData=0.
- Latency from req sampled in IDLE:
  - write: gnt 1 cycle later; memory written at the end of that cycle.
  - read: rdValid 2 cycles later.
  - Back-to-back occupancy is 2 cycles per write and 3 cycles per read.
- Requester rules:
  - Hold req, wrEn, addr and wrData stable until served.
  - Drop req at the edge ending the gnt cycle (write) or the rdValid cycle (read).
  - req is ignored in ACCESS and READ, so a held req cannot be double-served.
- Fairness: a core that holds req is granted within CORE_COUNT arbitrations.
- Simultaneous requests are resolved only by the pointer; there is no fixed priority.
- Pointer wrap: from CORE_COUNT-1 the pointer goes to 0.
- Signals of a non-requesting core (addr, wrData, wrEn with req low) have no effect.
- Reset mid-operation:
  - A write presented in the ACCESS cycle that coincides with reset is committed by the memory at that edge.
  - An interrupted read produces no rdValid.
  - The pointer returns to 0.
- gnt and rdValid are never both non-zero, and each has at most one bit set.
- Outputs are decoded from registered state and latches only; there are no combinational paths from req to the mem* outputs.

Test Plan:
- Reset then idle: rstN=0 for 2 cycles with random req -> all outputs 0, busy=0; after release with req=0, outputs stay 0.
- Single write: core 2 req=1, wrEn=1, addr=0x05A, wrData=0x123 -> next cycle gnt=4'b0100, memAddr=0x05A, memWrEn=1, memWrData=0x123; IDLE the cycle after.
- Single read: memory holds 0xABC at 0x010; core 1 reads 0x010 -> gnt=4'b0010 at T+1 with memWrEn=0; rdValid=4'b0010 and rdData=0xABC at T+2.
- Round-robin: all four cores request reads simultaneously and each drops req after its rdValid -> grant order 0,1,2,3; then core 0 and core 3 re-request together -> core 0 is served first (pointer wrapped to 0).
- Starvation: core 0 requests continuously and core 3 requests once -> core 3 is granted within 4 arbitrations and gnt never repeats for the same held request.
- Reset in READ: rstN=0 during core 1's READ cycle -> no rdValid; next cycle IDLE with all outputs 0; a subsequent simultaneous req from cores 1 and 2 grants core 1 first (pointer=0).
